// File: rtl/score_seg_display.sv
// Pong score display: double-dabble BCD conversion of both scores, plus a
// registered 4-digit multiplex scan for the Basys3 seven-segment display.
module score_seg_display #(
    parameter int unsigned REFRESH_DIV = 65000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    input  logic       upd,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);
    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [2:0]      iter;
    logic            pending;
    logic            load;
    logic [6:0]      bin_l, bin_r;
    logic [3:0]      tens_l, ones_l, tens_r, ones_r;
    logic [3:0][3:0] digits;
    logic [CW-1:0]   refresh_cnt;
    logic [1:0]      idx, idx_nxt;
    logic            wrap;
    logic [3:0]      sel_digit;
    logic [6:0]      seg_nxt;

    function automatic logic [6:0] clamp99(input logic [6:0] s);
        return (s > 7'd99) ? 7'd99 : s;
    endfunction

    // One double-dabble iteration on {tens, ones, bin}: add-3 correction, then shift.
    function automatic logic [14:0] dd_step(input logic [14:0] v);
        logic [3:0] t, o;
        t = v[14:11];
        o = v[10:7];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[2:0], o, v[6:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: if (upd) begin
                state_nxt = SHIFT;
                load      = 1'b1;
            end
            SHIFT: if (iter == 3'd6) state_nxt = COMMIT;
            COMMIT: begin
                // A request landing on the commit edge is served like a pending one.
                if (pending || upd) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_l   <= '0;
            bin_r   <= '0;
            tens_l  <= '0;
            ones_l  <= '0;
            tens_r  <= '0;
            ones_r  <= '0;
            iter    <= '0;
            pending <= 1'b0;
            digits  <= '0;
        end else begin
            if (state == COMMIT) digits <= {tens_l, ones_l, tens_r, ones_r};
            if (load) begin
                bin_l  <= clamp99(score_l);
                bin_r  <= clamp99(score_r);
                tens_l <= '0;
                ones_l <= '0;
                tens_r <= '0;
                ones_r <= '0;
                iter   <= '0;
            end else if (state == SHIFT) begin
                {tens_l, ones_l, bin_l} <= dd_step({tens_l, ones_l, bin_l});
                {tens_r, ones_r, bin_r} <= dd_step({tens_r, ones_r, bin_r});
                iter <= iter + 3'd1;
            end
            if (state == SHIFT && upd) pending <= 1'b1;
            else if (state == COMMIT)  pending <= 1'b0;
        end
    end

    assign wrap      = (refresh_cnt == CW'(REFRESH_DIV - 1));
    assign idx_nxt   = idx + 2'd1;
    assign sel_digit = digits[idx_nxt];

    // Odd indices are the tens positions of each score.
    always_comb begin
        seg_nxt = seg_code(sel_digit);
        if (BLANK_LZ && idx_nxt[0] && sel_digit == 4'd0) seg_nxt = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            idx         <= 2'd3;
            an          <= '1;
            seg         <= '1;
        end else if (wrap) begin
            refresh_cnt <= '0;
            idx         <= idx_nxt;
            an          <= ~(4'b0001 << idx_nxt);
            seg         <= seg_nxt;
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end
endmodule

// File: doc/score_seg_display.md
Name: score_seg_display

Overview:
- Consumes the two Pong player scores produced by the game logic and drives the Basys3 4-digit seven-segment display.
- Sits between the score counters and the board `an`/`seg` pins, in the 65 MHz pixel clock domain.
- Converts each score to two BCD digits with an iterative double-dabble FSM.
- Time-multiplexes the four digits: left score on digits 3..2, right score on digits 1..0.

Parameters:
- REFRESH_DIV, 65000: clock cycles each digit stays enabled (1 ms at 65 MHz); must be >= 2.
- BLANK_LZ, 1: 1 blanks a tens digit when it is 0; 0 shows it.

Ports:
- clk  input  1  pixel clock, 65 MHz; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- score_l  input  7  left player score, unsigned binary.
- score_r  input  7  right player score, unsigned binary.
- upd  input  1  single-cycle request to convert and display the current scores.
- busy  output  1  conversion in progress.
- an  output  4  digit anodes, active-low, one-hot-low when enabled.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset values (async, rst_n low): busy=0, an=4'b1111, seg=7'b1111111.
- Reset clears all four displayed digit registers to 0, the refresh counter to 0, the digit index to 3, and the pending flag to 0. FSM goes to IDLE.
- Scores above 99 are clamped to 99 when captured.
- FSM IDLE:
  - upd=1 at an edge captures the clamped score_l and score_r into shift registers and clears the BCD accumulators.
  - Same edge: go to SHIFT, iteration count 0, busy becomes 1.
- FSM SHIFT, 7 cycles, both scores in parallel, each cycle:
  - any BCD nibble >= 5 gets +3;
  - then shift {tens, ones, bin} left by 1.
  - After the 7th cycle go to COMMIT.
- FSM COMMIT, 1 cycle:
  - Write the 4 result nibbles into the display digit registers.
  - If pending=1: clear pending, recapture the current scores (clamped), go to SHIFT, keep busy=1.
  - Otherwise go to IDLE; busy becomes 0 after this edge.
- Latency: upd sampled at edge E0 -> digit registers updated at edge E8; busy high from after E0 through E8.
- upd while busy (SHIFT or COMMIT) sets pending; multiple requests collapse to one.
- The in-flight conversion is never disturbed; the pending conversion samples scores at the COMMIT edge.
- Refresh counter:
  - counts 0..REFRESH_DIV-1 and wraps;
  - on wrap, the digit index advances 3->2->1->0->3;
  - the index starts at 3, so the first enabled digit after reset is digit 0, entered one full period after reset.
- an and seg are registered and updated together on each wrap edge:
  - an = ~(4'b0001 << idx);
  - seg = encoding of that digit register.
  - Between wraps an/seg hold, so the display never shows a half-updated digit.
- A digit register change (COMMIT) becomes visible at the next wrap edge.
- Blanking: if BLANK_LZ=1 and the selected digit is 3 or 1 with value 0, seg=7'b1111111. Ones digits are never blanked.
- Segment codes (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001;
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Any other value = 1111111.
- Reset mid-conversion aborts immediately to reset values. Displayed digits return to 0 and no partial result is ever committed.

Test Plan:
- Reset then REFRESH_DIV=4, BLANK_LZ=1, no upd -> an cycles 1110,1101,1011,0111, each held 4 cycles. seg is 1000000 on digits 0 and 2, 1111111 on digits 1 and 3.
- score_l=37, score_r=5, upd pulse -> busy high for cycles E0+1..E8. Next scan shows digit3=0110000 (3), digit2=1111000 (7), digit1 blank, digit0=0010010 (5).
- score_l=120, score_r=99, upd -> all four digits show 0010000 (9).
- upd with 12/34, second upd at E3 after score change to 56/78 -> first result 12/34 committed at E8. busy stays high through E16, and 56/78 is committed at E16.
- BLANK_LZ=0, scores 7/0, upd -> digits 0,7,0,0 shown as 1000000,1111000,1000000,1000000.
- rst_n low at E4 of a conversion -> an=1111, seg=1111111, busy=0 asynchronously. After release the display shows the 0/0 pattern and no stale digits.
